fifo_rptr_empty: RTL and testbench
==================================

Name: fifo_rptr_empty

Overview:
Read-side pointer and empty-flag generator for the asynchronous FIFO. It is the read-domain neighbour of the pointer comparator.
- Takes the comparator's active-low almost-empty (`i_aempty_n`).
- Drives the Gray read pointer back into the comparator.
- Provides the binary read address to the dual-port RAM, a qualified read enable, and a registered empty flag with a two-flop deassert path.
- Consumers issue `i_rinc` and must watch `o_rempty`.

Parameters:
- ADDR_WIDTH, 4: pointer/address width. FIFO depth = 2**ADDR_WIDTH. Must be >= 2, because the comparator decodes the top two Gray bits as quadrant.

Ports:
- `i_rclk`  in  1  read-domain clock; all state updates on rising edge
- `i_rrst`  in  1  reset, synchronous, active-high
- `i_rinc`  in  1  read request from consumer
- `i_aempty_n`  in  1  almost-empty from comparator, active-low, asynchronous to `i_rclk`
- `o_rempty`  out  1  FIFO empty, registered
- `o_ren`  out  1  RAM read enable = `i_rinc & ~o_rempty` (combinational)
- `o_raddr`  out  ADDR_WIDTH  binary read address to RAM, registered
- `o_rptr`  out  ADDR_WIDTH  Gray read pointer to comparator, registered
- `o_runderflow`  out  1  sticky: read attempted while empty

Behaviour:

Reset (`i_rrst` high at a rising `i_rclk` edge):
- `rbin`, `o_raddr`, `o_rptr` = 0.
- `rempty1`, `o_rempty` = 1.
- `o_runderflow` = 0.
- `i_rrst` overrides every other input, including mid-read.

Read acceptance:
- accept = `i_rinc & ~o_rempty`, evaluated from pre-edge values.
- On accept: `rbin_next = rbin + 1`, modulo 2**ADDR_WIDTH. Wrap from all-ones to 0 has no special case.
- `o_raddr <= rbin_next`.
- `o_rptr <= rbin_next ^ (rbin_next >> 1)`.
- Exactly one Gray bit changes per accepted read, including across the wrap.
- Without accept, pointers hold.

Data timing:
- RAM data for the current `o_raddr` is valid in the same cycle as `o_ren`; the RAM reads asynchronously.
- Pointer-to-comparator latency is 1 edge after accept.

Empty flag:
- Two flops, `rempty1` then `o_rempty`.
- While `i_aempty_n` is low, both flops are asynchronously set to 1. This is the only asynchronous element in the block. It is required so that empty asserts without a clock edge and no read can slip past the comparator.
- When `i_aempty_n` is high, on each edge: `rempty1 <= 0`, `o_rempty <= rempty1`.
- Deassert latency is therefore exactly 2 rising edges after `i_aempty_n` rises (metastability guard).
- If `i_aempty_n` pulses low during the deassert window, the chain restarts and needs 2 fresh edges.
- Synchronous `i_rrst` takes priority over clearing. The async set and the reset both drive 1, so there is no conflict.

Underflow:
- `i_rinc & o_rempty` at an edge sets `o_runderflow <= 1`.
- Pointers do not move; `o_ren` stays 0.
- `o_runderflow` clears only on `i_rrst`.

Simultaneous events:
- An accepted read on the same edge that `i_aempty_n` falls still completes; the pointer advances.
- `o_rempty` is already high for the following cycle, so the next request is blocked.

Full detection is not this block's concern; `o_afull_n` is consumed on the write side.

Test Plan:
1. Reset with `i_aempty_n`=0 -> after first edge: `o_rempty`=1, `o_raddr`=0, `o_rptr`=0, `o_runderflow`=0, `o_ren`=0.
2. Hold `i_aempty_n`=0, raise it at t0 -> `o_rempty` stays 1 at edge 1 and is 0 after edge 2. Drop `i_aempty_n` mid-cycle -> `o_rempty`=1 immediately, with no edge needed.
3. ADDR_WIDTH=4, `o_rempty`=0, `i_rinc`=1 for 16 edges -> `o_rptr` sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0. `o_raddr` runs 0..F, then 0. Each step has single-bit Gray Hamming distance.
4. `o_rempty`=1, `i_rinc`=1 for 3 edges -> `o_raddr`/`o_rptr` unchanged, `o_ren`=0, `o_runderflow`=1 and stays 1 after `i_rinc`=0 until `i_rrst`.
5. `o_raddr`=5 with reads in flight, assert `i_rrst` for one edge with `i_rinc`=1 and `i_aempty_n`=1 -> after the edge: `o_raddr`=0, `o_rptr`=0, `o_rempty`=1. After release, `o_rempty` drops 2 edges later.
6. Deassert window: raise `i_aempty_n`, pulse it low for 3 ns between edges 1 and 2 -> `o_rempty` stays 1 until 2 edges after the pulse ends.

Source files
------------

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty-flag generator for the asynchronous FIFO.
// Keeps the binary read address for the RAM, returns the Gray read pointer
// to the comparator, and turns the comparator's almost-empty into a
// registered empty flag. Empty is set at once; it only clears after two
// read-clock edges.
// ADDR_WIDTH must be at least 2, because the comparator decodes the top
// two Gray bits as the quadrant.
module fifo_rptr_empty #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_rclk,
  input  logic                  i_rrst,
  input  logic                  i_rinc,
  input  logic                  i_aempty_n,
  output logic                  o_rempty,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic [ADDR_WIDTH-1:0] o_rptr,
  output logic                  o_runderflow
);

  logic [ADDR_WIDTH-1:0] rbin_q, rbin_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic                  runderflow_q, runderflow_d;
  logic                  rempty1_q, rempty_q;
  logic                  accept;

  // A read is accepted only when the flag seen before the edge says not empty.
  assign accept = i_rinc & ~rempty_q;

  // Next pointer values. The binary count wraps naturally, and the Gray code
  // is derived from the incremented binary value.
  always_comb begin
    rbin_d       = rbin_q;
    rptr_d       = rptr_q;
    runderflow_d = runderflow_q | (i_rinc & rempty_q);
    if (accept) begin
      rbin_d = rbin_q + 1'b1;
      rptr_d = rbin_d ^ (rbin_d >> 1);
    end
  end

  // Pointer and sticky underflow registers. Reset overrides any read in flight.
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      runderflow_q <= runderflow_d;
    end
  end

  // Empty synchroniser. A low almost-empty sets both flops without waiting
  // for a clock, so a read cannot slip past the comparator. Once almost-empty
  // is released, a zero shifts through two flops. Reset also drives ones, so
  // reset and the asynchronous set never conflict.
  always_ff @(posedge i_rclk or negedge i_aempty_n) begin
    if (!i_aempty_n) begin
      rempty1_q <= 1'b1;
      rempty_q  <= 1'b1;
    end else if (i_rrst) begin
      rempty1_q <= 1'b1;
      rempty_q  <= 1'b1;
    end else begin
      rempty1_q <= 1'b0;
      rempty_q  <= rempty1_q;
    end
  end

  // The RAM reads asynchronously, so the enable is combinational.
  assign o_ren        = accept;
  assign o_rempty     = rempty_q;
  assign o_raddr      = rbin_q;
  assign o_rptr       = rptr_q;
  assign o_runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty. A small bench-side model pushes the
// expected post-edge state into a queue. That entry is popped and compared
// once the edge has occurred.
module tb_fifo_rptr_empty;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic          aempty_n;
  logic          rempty;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [AW-1:0] rptr;
  logic          runderflow;

  fifo_rptr_empty #(.ADDR_WIDTH(AW)) dut (
    .i_rclk       (clk),
    .i_rrst       (rrst),
    .i_rinc       (rinc),
    .i_aempty_n   (aempty_n),
    .o_rempty     (rempty),
    .o_ren        (ren),
    .o_raddr      (raddr),
    .o_rptr       (rptr),
    .o_runderflow (runderflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          empty;
    logic [AW-1:0] addr;
    logic [AW-1:0] gray;
    logic          uf;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Bench model of the read side.
  logic [AW-1:0] m_bin   = '0;
  logic          m_e1    = 1'b1;
  logic          m_empty = 1'b1;
  logic          m_uf    = 1'b0;

  logic [AW-1:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] to_gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock cycle: drive inputs, check ren, predict the edge, then compare.
  task automatic step(input logic inc, input logic rst, input string tag);
    exp_t e;
    exp_t got;
    logic acc;
    rinc = inc;
    rrst = rst;
    #1;
    if (!rst) chk({tag, ".ren"}, 32'(ren), 32'(inc & ~m_empty));
    acc = inc & ~m_empty;
    if (rst) begin
      m_bin = '0; m_e1 = 1'b1; m_empty = 1'b1; m_uf = 1'b0;
    end else begin
      if (acc) m_bin = m_bin + 1'b1;
      if (inc & m_empty) m_uf = 1'b1;
      if (aempty_n) begin
        m_empty = m_e1;
        m_e1    = 1'b0;
      end else begin
        m_empty = 1'b1;
        m_e1    = 1'b1;
      end
    end
    e.empty = m_empty; e.addr = m_bin; e.gray = to_gray(m_bin); e.uf = m_uf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".rempty"}, 32'(rempty), 32'(got.empty));
    chk({tag, ".raddr"}, 32'(raddr), 32'(got.addr));
    chk({tag, ".rptr"}, 32'(rptr), 32'(got.gray));
    chk({tag, ".underflow"}, 32'(runderflow), 32'(got.uf));
    $display("[TB] %s inc=%0b rst=%0b aempty_n=%0b -> rempty=%0b raddr=%0h rptr=%0h uf=%0b",
             tag, inc, rst, aempty_n, rempty, raddr, rptr, runderflow);
  endtask

  task automatic drop_aempty();
    aempty_n = 1'b0;
    m_e1 = 1'b1;
    m_empty = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] prev;
    rrst = 1'b1;
    rinc = 1'b0;
    aempty_n = 1'b1;
    #2;
    drop_aempty();

    // 1: reset while almost-empty is held low.
    step(1'b0, 1'b1, "reset");
    chk("reset.ren", 32'(ren), 32'd0);

    // 2: empty stays high while almost-empty is low, then clears two edges after release.
    step(1'b0, 1'b0, "hold_low");
    aempty_n = 1'b1;
    step(1'b0, 1'b0, "deassert_e1");
    step(1'b0, 1'b0, "deassert_e2");
    #2;
    drop_aempty();
    #1;
    chk("async_set.rempty", 32'(rempty), 32'd1);
    aempty_n = 1'b1;
    step(1'b0, 1'b0, "rearm_e1");
    step(1'b0, 1'b0, "rearm_e2");

    // 3: sixteen reads walk the full Gray sequence and wrap to 0.
    prev = rptr;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("gray_tab%0d", i), 32'(rptr), 32'(gray_tab[i]));
      step(1'b1, 1'b0, $sformatf("read%0d", i));
      chk($sformatf("gray_hd%0d", i), 32'($countones(rptr ^ prev)), 32'd1);
      prev = rptr;
    end
    chk("wrap.rptr", 32'(rptr), 32'd0);
    chk("wrap.raddr", 32'(raddr), 32'd0);

    // Advance to address 3 before going empty.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $sformatf("pre_uf%0d", i));

    // 4: reads while empty do not move pointers and set sticky underflow.
    #2;
    drop_aempty();
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $sformatf("underflow%0d", i));
    step(1'b0, 1'b0, "uf_sticky0");
    step(1'b0, 1'b0, "uf_sticky1");

    // 5: reset during reads at address 5.
    aempty_n = 1'b1;
    step(1'b0, 1'b0, "r5_e1");
    step(1'b0, 1'b0, "r5_e2");
    step(1'b1, 1'b0, "r5_rd0");
    step(1'b1, 1'b0, "r5_rd1");
    chk("r5.raddr", 32'(raddr), 32'd5);
    step(1'b1, 1'b1, "mid_reset");
    step(1'b1, 1'b0, "post_rst1");
    step(1'b1, 1'b0, "post_rst2");
    step(1'b0, 1'b0, "post_rst3");

    // 6: a glitch low during the deassert window restarts the two-edge count.
    #2;
    drop_aempty();
    #1;
    aempty_n = 1'b1;
    step(1'b0, 1'b0, "win_e1");
    #2;
    drop_aempty();
    #3;
    chk("win_pulse.rempty", 32'(rempty), 32'd1);
    aempty_n = 1'b1;
    step(1'b0, 1'b0, "win_after1");
    step(1'b0, 1'b0, "win_after2");
    step(1'b1, 1'b0, "win_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
